// File: rtl/image_kernel_window_3x3.sv
// 3x3 sliding-window generator for an AXI-Stream raster video input, built on two line buffers.
// Optional macro IMAGE_KERNEL_LINE_ERR_CNT_EN adds a saturating malformed-line counter output.
module image_kernel_window_3x3 #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_image_kernel_buffer,
  output logic                  o_image_data_valid,
  output logic                  o_start_of_frame
`ifdef IMAGE_KERNEL_LINE_ERR_CNT_EN
  ,
  output logic [15:0]           o_line_err_cnt
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  ready_q;
  logic                  valid_q, valid_d;
  logic                  sof_q, sof_d;
  logic                  accept;
  logic                  proc;
  logic                  line_end;
  logic [COL_W-1:0]      cur_col;
  logic [ROW_W-1:0]      cur_row;

  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] win_q;
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

  assign accept = s_axis_tvalid & ready_q;

  // Next-state: a tuser pixel always lands at (0,0) and its tlast is ignored
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    proc     = 1'b0;
    line_end = 1'b0;
    cur_col  = col_q;
    cur_row  = row_q;

    if (s_axis_tuser) begin
      cur_col = '0;
      cur_row = '0;
    end

    case (state_q)
      WAIT_SOF: proc = accept & s_axis_tuser;
      RUN:      proc = accept;
      default:  proc = 1'b0;
    endcase

    if (proc) begin
      state_d  = RUN;
      valid_d  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      sof_d    = (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));
      line_end = !s_axis_tuser && (s_axis_tlast || (cur_col == LAST_COL));
      if (line_end) begin
        col_d = '0;
        if (cur_row == LAST_ROW) begin
          row_d   = '0;
          state_d = WAIT_SOF;
        end else begin
          row_d = cur_row + ROW_W'(1);
        end
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= WAIT_SOF;
      col_q   <= '0;
      row_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ready_q <= 1'b1;
      valid_q <= valid_d;
      sof_q   <= sof_d;
    end
  end

  // Window shifts left; the new right column is {lb1, lb0, pixel} from oldest to newest line
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      win_q <= '0;
    end else if (proc) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[2][2] <= s_axis_tdata;
      win_q[1][2] <= lb0[cur_col];
      win_q[0][2] <= lb1[cur_col];
    end
  end

  // Line buffers are storage only; stale contents never reach a valid window
  always_ff @(posedge i_clk) begin
    if (proc) begin
      lb0[cur_col] <= s_axis_tdata;
      lb1[cur_col] <= lb0[cur_col];
    end
  end

`ifdef IMAGE_KERNEL_LINE_ERR_CNT_EN
  logic [15:0] err_q;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      err_q <= '0;
    end else if (line_end && (s_axis_tlast != (cur_col == LAST_COL)) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign o_line_err_cnt = err_q;
`endif

  assign s_axis_tready         = ready_q;
  assign o_image_kernel_buffer = win_q;
  assign o_image_data_valid    = valid_q;
  assign o_start_of_frame      = sof_q;

endmodule

// File: tb/tb_image_kernel_window_3x3.sv
// Bench for image_kernel_window_3x3: directed frame scenarios plus randomized frames,
// checked every cycle against a column-history reference model.
module tb_image_kernel_window_3x3;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;

  logic          i_clk = 1'b0;
  logic          i_aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tuser;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [0:2][0:2][DW-1:0] o_image_kernel_buffer;
  logic          o_image_data_valid;
  logic          o_start_of_frame;
`ifdef IMAGE_KERNEL_LINE_ERR_CNT_EN
  logic [15:0]   o_line_err_cnt;
`endif

  image_kernel_window_3x3 #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(3),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .i_clk                (i_clk),
    .i_aresetn            (i_aresetn),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tuser         (s_axis_tuser),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .o_image_kernel_buffer(o_image_kernel_buffer),
    .o_image_data_valid   (o_image_data_valid),
    .o_start_of_frame     (o_start_of_frame)
`ifdef IMAGE_KERNEL_LINE_ERR_CNT_EN
    ,
    .o_line_err_cnt       (o_line_err_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame position, per-column pixel history, current window
  bit            m_run;
  int            m_col, m_row, m_err;
  logic [DW-1:0] m_win [3][3];
  logic [DW-1:0] hist [W][$];
  logic          exp_valid, exp_sof, exp_ready;

  int  win_count, sof_count, sof_at, pix_n;
  bit  first_seen;
  logic [0:2][0:2][DW-1:0] first_win, ref_win, ew;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_col = 0; m_row = 0; m_err = 0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) m_win[r][c] = '0;
    exp_valid = 0; exp_sof = 0; exp_ready = 0;
  endtask

  task automatic model_clock();
    int c, r;
    bit acc, proc, endline;
    acc  = s_axis_tvalid && exp_ready;
    proc = acc && (m_run || s_axis_tuser);
    exp_valid = 0;
    exp_sof   = 0;
    if (proc) begin
      c = s_axis_tuser ? 0 : m_col;
      r = s_axis_tuser ? 0 : m_row;
      for (int rr = 0; rr < 3; rr++) begin
        m_win[rr][0] = m_win[rr][1];
        m_win[rr][1] = m_win[rr][2];
      end
      m_win[2][2] = s_axis_tdata;
      m_win[1][2] = hist[c][$];
      m_win[0][2] = hist[c][$-1];
      hist[c].push_back(s_axis_tdata);
      exp_valid = (r >= 2) && (c >= 2);
      exp_sof   = (r == 2) && (c == 2);
      endline   = !s_axis_tuser && (s_axis_tlast || c == W - 1);
      if (endline && (s_axis_tlast != (c == W - 1)) && m_err < 65535) m_err++;
      m_run = 1;
      if (endline) begin
        m_col = 0;
        if (r == H - 1) begin m_row = 0; m_run = 0; end
        else m_row = r + 1;
      end else begin
        m_col = c + 1;
        m_row = r;
      end
    end
    exp_ready = 1;
  endtask

  task automatic check_outputs();
    check("tready", 80'(s_axis_tready), 80'(exp_ready));
    check("valid", 80'(o_image_data_valid), 80'(exp_valid));
    check("sof", 80'(o_start_of_frame), 80'(exp_sof));
    if (exp_valid) begin
      for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ew[r][c] = m_win[r][c];
      check("window", 80'(o_image_kernel_buffer), 80'(ew));
    end
`ifdef IMAGE_KERNEL_LINE_ERR_CNT_EN
    check("err_cnt", 80'(o_line_err_cnt), 80'(m_err));
`endif
    if (o_image_data_valid) begin
      win_count++;
      if (!first_seen) begin first_seen = 1; first_win = o_image_kernel_buffer; end
    end
    if (o_start_of_frame) sof_count++;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic u, input logic l);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
    @(posedge i_clk);
    model_clock();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic begin_test();
    win_count = 0; sof_count = 0; first_seen = 0;
  endtask

  // mode 0: back-to-back, 1: tvalid toggling 1,0, 2: random data with random gaps
  task automatic send_frame(input int mode);
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++) begin
        if (mode == 2) while ($urandom_range(0, 3) == 0) idle(1);
        step(1'b1, (mode == 2) ? DW'($urandom) : DW'(r * W + c), r == 0 && c == 0, c == W - 1);
        if (mode == 1) idle(1);
      end
  endtask

  task automatic reset_dut();
    s_axis_tvalid = 0;
    i_aresetn = 0;
    model_reset();
    #1;
    check("rst_ready", 80'(s_axis_tready), 80'(0));
    check("rst_valid", 80'(o_image_data_valid), 80'(0));
    check("rst_sof", 80'(o_start_of_frame), 80'(0));
    check("rst_window", 80'(o_image_kernel_buffer), 80'(0));
`ifdef IMAGE_KERNEL_LINE_ERR_CNT_EN
    check("rst_err", 80'(o_line_err_cnt), 80'(0));
`endif
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_aresetn = 1;
    idle(2);
  endtask

  initial begin
    s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    for (int c = 0; c < int'(W); c++) begin hist[c].push_back('0); hist[c].push_back('0); end
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) ref_win[r][c] = DW'(r * 5 + c);
    reset_dut();

    // Reference frame, continuous valid
    begin_test();
    send_frame(0);
    idle(2);
    check("t032_windows", 80'(win_count), 80'(6));
    check("t032_first_win", 80'(first_win), 80'(ref_win));
    check("t032_sof_count", 80'(sof_count), 80'(1));

    // Same frame, tvalid toggling
    begin_test();
    send_frame(1);
    idle(2);
    check("t033_windows", 80'(win_count), 80'(6));
    check("t033_first_win", 80'(first_win), 80'(ref_win));

    // Pixels before start of frame are discarded
    begin_test();
    for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0, 1'($urandom));
    check("t034_no_win_pre_sof", 80'(win_count), 80'(0));
    send_frame(0);
    idle(2);
    check("t034_windows", 80'(win_count), 80'(6));
    check("t034_first_win", 80'(first_win), 80'(ref_win));

    // Short line: tlast at col 2 of row 1
    begin_test();
    for (int r = 0; r < int'(H); r++) begin
      int len;
      len = (r == 1) ? 3 : int'(W);
      for (int c = 0; c < len; c++) step(1'b1, DW'(100 + r * W + c), r == 0 && c == 0, c == len - 1);
    end
    idle(2);
    check("t035_windows", 80'(win_count), 80'(6));
`ifdef IMAGE_KERNEL_LINE_ERR_CNT_EN
    check("t035_err_cnt", 80'(o_line_err_cnt), 80'(1));
`endif

    // Restart at row 2, col 3
    begin_test();
    for (int i = 0; i < 13; i++) step(1'b1, DW'(50 + i), i == 0, (i % W) == W - 1);
    check("t036_pre_restart_windows", 80'(win_count), 80'(1));
    sof_at = -1;
    for (int n = 1; n <= int'(W * H); n++) begin
      step(1'b1, DW'($urandom), n == 1, ((n - 1) % W) == W - 1);
      if (o_start_of_frame && sof_at < 0) sof_at = n;
    end
    idle(2);
    check("t036_sof_after", 80'(sof_at), 80'(13));
    check("t036_windows", 80'(win_count), 80'(7));

    // Reset pulsed mid-row 2
    begin_test();
    for (int i = 0; i < 14; i++) step(1'b1, DW'($urandom), i == 0, (i % W) == W - 1);
    check("t037_pre_reset_windows", 80'(win_count), 80'(2));
    reset_dut();
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0, 1'($urandom));
    check("t037_no_win_after_reset", 80'(win_count), 80'(2));
    send_frame(0);
    idle(2);
    check("t037_windows", 80'(win_count), 80'(8));

    // Randomized frames with gaps
    for (int f = 0; f < 4; f++) begin
      begin_test();
      send_frame(2);
      idle(3);
      check("rand_windows", 80'(win_count), 80'(6));
      check("rand_sof_count", 80'(sof_count), 80'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
